// File: rtl/core_inst_buffer.sv
// core_inst_buffer: in-order instruction queue between core_ifetch and decode.
// Fetch delivers up to two words per cycle (shared PC and attached info). The
// words are compacted so that an F2 pair with only the high word valid still
// lands in a single entry. Decode sees the two oldest entries every cycle.
//
// Optional feature: define INST_BUFFER_BYPASS_EN to let an empty buffer forward
// the compacted fetch slots straight to decode in the same cycle. Without the
// macro there is no combinational input-to-output data path.
module core_inst_buffer #(
    parameter int DEPTH               = 8,
    parameter int ATTACHED_INFO_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  logic [1:0]                          valid_i,
    input  logic [1:0][31:0]                    inst_i,
    input  logic [31:0]                         pc_i,
    input  logic [ATTACHED_INFO_WIDTH-1:0]      attached_i,
    output logic                                full_o,
    output logic [1:0]                          valid_o,
    output logic [1:0][31:0]                    inst_o,
    output logic [1:0][31:0]                    pc_o,
    output logic [1:0][ATTACHED_INFO_WIDTH-1:0] attached_o,
    input  logic [1:0]                          ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = ATTACHED_INFO_WIDTH;

    // Queue bookkeeping
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Entry storage; no reset, contents only meaningful between head and tail
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [AW-1:0] r_mem_att  [DEPTH];

    // Compacted fetch slots: slot 0 is the oldest valid word of the pair
    logic [1:0][31:0] w_cmp_inst;
    logic [1:0][31:0] w_cmp_pc;
    logic [1:0]       w_in_n;

    // Read side
    logic [PW-1:0]    w_rd_idx1;
    logic [1:0]       w_vld;
    logic [1:0][31:0] w_rd_inst;
    logic [1:0][31:0] w_rd_pc;
    logic [1:0][AW-1:0] w_rd_att;
    logic             w_byp;

    // Pop / push control
    logic [1:0]       w_n_out;
    logic [1:0]       w_st_pop;
    logic             w_push_en;
    logic [1:0]       w_skip;
    logic [1:0]       w_n_wr;
    logic [1:0]       w_wr_en;
    logic [1:0]       w_wr_src;
    logic [PW-1:0]    w_wr_idx1;

    assign w_in_n = {1'b0, valid_i[0]} + {1'b0, valid_i[1]};

    // Compaction: when the low word is absent the high word moves to slot 0
    always_comb begin
        w_cmp_inst[0] = valid_i[0] ? inst_i[0] : inst_i[1];
        w_cmp_pc[0]   = {pc_i[31:3], ~valid_i[0], 2'b00};
        w_cmp_inst[1] = inst_i[1];
        w_cmp_pc[1]   = {pc_i[31:3], 3'b100};
    end

    // Occupancy-only full flag; never depends on ready_i
    assign full_o = (r_count > CW'(DEPTH - 2));

`ifdef INST_BUFFER_BYPASS_EN
    assign w_byp = (r_count == '0) && !flush_i;
`else
    assign w_byp = 1'b0;
`endif

    assign w_rd_idx1 = r_head + PW'(1);

    // Output selection: storage normally, compacted fetch slots when bypassing
    always_comb begin
        w_vld        = {(r_count >= CW'(2)), (r_count != '0)};
        w_rd_inst[0] = r_mem_inst[r_head];
        w_rd_inst[1] = r_mem_inst[w_rd_idx1];
        w_rd_pc[0]   = r_mem_pc[r_head];
        w_rd_pc[1]   = r_mem_pc[w_rd_idx1];
        w_rd_att[0]  = r_mem_att[r_head];
        w_rd_att[1]  = r_mem_att[w_rd_idx1];
        if (w_byp) begin
            w_vld        = {(w_in_n == 2'd2), (w_in_n != 2'd0)};
            w_rd_inst    = w_cmp_inst;
            w_rd_pc      = w_cmp_pc;
            w_rd_att[0]  = attached_i;
            w_rd_att[1]  = attached_i;
        end
        if (flush_i) begin
            w_vld = 2'b00;
        end
    end

    // Drive outputs; data of an invalid slot is held at zero
    always_comb begin
        valid_o = w_vld;
        for (int k = 0; k < 2; k++) begin
            inst_o[k]     = w_vld[k] ? w_rd_inst[k] : 32'd0;
            pc_o[k]       = w_vld[k] ? w_rd_pc[k]   : 32'd0;
            attached_o[k] = w_vld[k] ? w_rd_att[k]  : '0;
        end
    end

    // Slot 1 is only taken together with slot 0
    assign w_n_out = {1'b0, valid_o[0] & ready_i[0]}
                   + {1'b0, valid_o[1] & ready_i[0] & ready_i[1]};

    // Entries popped by a bypass were never stored, so head does not move
    assign w_st_pop  = w_byp ? 2'd0 : w_n_out;
    assign w_push_en = !full_o && !flush_i;
    assign w_skip    = w_byp ? w_n_out : 2'd0;

    // Decide how many compacted slots get stored and from which slot
    always_comb begin
        w_n_wr   = 2'd0;
        w_wr_en  = 2'b00;
        w_wr_src = 2'b10;
        if (w_push_en) begin
            w_n_wr = w_in_n - w_skip;
        end
        w_wr_en[0]  = (w_n_wr != 2'd0);
        w_wr_en[1]  = (w_n_wr == 2'd2);
        w_wr_src[0] = (w_skip != 2'd0);
        w_wr_src[1] = 1'b1;
    end

    assign w_wr_idx1 = r_tail + PW'(1);

    // Entry writes at tail and tail+1
    always_ff @(posedge clk) begin
        if (w_wr_en[0]) begin
            r_mem_inst[r_tail] <= w_cmp_inst[w_wr_src[0]];
            r_mem_pc[r_tail]   <= w_cmp_pc[w_wr_src[0]];
            r_mem_att[r_tail]  <= attached_i;
        end
        if (w_wr_en[1]) begin
            r_mem_inst[w_wr_idx1] <= w_cmp_inst[w_wr_src[1]];
            r_mem_pc[w_wr_idx1]   <= w_cmp_pc[w_wr_src[1]];
            r_mem_att[w_wr_idx1]  <= attached_i;
        end
    end

    // Pointer and occupancy update; flush outranks push and pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_st_pop);
            r_tail  <= r_tail + PW'(w_n_wr);
            r_count <= r_count + CW'(w_n_wr) - CW'(w_st_pop);
        end
    end

endmodule
